// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: phase-locks column/row counters to an incoming VGA HSync/VSync/RGB stream.
// Define VGA_RX_SYNC_EN to add a two-flop synchroniser on every input (pin-to-output latency 4, else 2).
module vga_sync_receiver #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_SYNC_COL = 656,
  parameter int V_SYNC_ROW = 490,
  parameter int LOCK_LINES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [2:0] i_Red,
  input  logic [2:0] i_Grn,
  input  logic [2:0] i_Blu,
  output logic [9:0] o_col_num,
  output logic [9:0] o_row_num,
  output logic       o_active,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic [2:0] o_reds,
  output logic [2:0] o_greens,
  output logic [2:0] o_blues
);

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  H_SYNC   = 10'(H_SYNC_COL);
  localparam logic [9:0]  V_SYNC   = 10'(V_SYNC_ROW);
  localparam logic [7:0]  LOCK_CNT = 8'(LOCK_LINES);
  localparam logic [11:0] TMO_LAST = 12'(2 * H_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic       hs_in_s, vs_in_s;
  logic [8:0] rgb_in_s;

`ifdef VGA_RX_SYNC_EN
  logic [1:0] hs_meta_r, vs_meta_r;
  logic [8:0] rgb_meta0_r, rgb_meta1_r;

  // Two-flop synchroniser ahead of the s1 stage
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      hs_meta_r   <= 2'b11;
      vs_meta_r   <= 2'b11;
      rgb_meta0_r <= 9'd0;
      rgb_meta1_r <= 9'd0;
    end else begin
      hs_meta_r   <= {hs_meta_r[0], i_HSync};
      vs_meta_r   <= {vs_meta_r[0], i_VSync};
      rgb_meta0_r <= {i_Red, i_Grn, i_Blu};
      rgb_meta1_r <= rgb_meta0_r;
    end
  end

  assign hs_in_s  = hs_meta_r[1];
  assign vs_in_s  = vs_meta_r[1];
  assign rgb_in_s = rgb_meta1_r;
`else
  assign hs_in_s  = i_HSync;
  assign vs_in_s  = i_VSync;
  assign rgb_in_s = {i_Red, i_Grn, i_Blu};
`endif

  logic       s1_hs_r, s1_vs_r, s2_hs_r, s2_vs_r;
  logic [8:0] s1_rgb_r;
  state_t     state_r, state_s;
  logic [9:0] col_r, col_s, row_r, row_s, col_inc_s, row_inc_s;
  logic [7:0] good_r, good_s;
  logic       vs_seen_r, vs_seen_s;
  logic [11:0] tmo_r, tmo_s;
  logic       hs_fall_s, vs_fall_s, match_s, timeout_s, active_s;
  logic       active_r, locked_r, frame_start_r;
  logic [8:0] rgb_out_r;

  // Input capture stage and edge-detect history
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      s1_hs_r  <= 1'b1;
      s1_vs_r  <= 1'b1;
      s2_hs_r  <= 1'b1;
      s2_vs_r  <= 1'b1;
      s1_rgb_r <= 9'd0;
    end else begin
      s1_hs_r  <= hs_in_s;
      s1_vs_r  <= vs_in_s;
      s2_hs_r  <= s1_hs_r;
      s2_vs_r  <= s1_vs_r;
      s1_rgb_r <= rgb_in_s;
    end
  end

  assign hs_fall_s = s2_hs_r & ~s1_hs_r;
  assign vs_fall_s = s2_vs_r & ~s1_vs_r;
  assign col_inc_s = (col_r == H_LAST) ? 10'd0 : col_r + 10'd1;
  assign row_inc_s = (row_r == V_LAST) ? 10'd0 : row_r + 10'd1;
  assign match_s   = hs_fall_s && (col_inc_s == H_SYNC);
  assign timeout_s = !hs_fall_s && (tmo_r == TMO_LAST);

  // Next-state, counter and lock-qualification logic
  always_comb begin
    state_s   = state_r;
    col_s     = col_r;
    row_s     = row_r;
    good_s    = good_r;
    vs_seen_s = vs_seen_r;
    tmo_s     = tmo_r;
    case (state_r)
      ST_SEARCH: begin
        row_s     = 10'd0;
        good_s    = 8'd0;
        vs_seen_s = 1'b0;
        tmo_s     = 12'd0;
        if (hs_fall_s) begin
          col_s   = H_SYNC;
          state_s = ST_TRACK;
        end else begin
          col_s   = 10'd0;
          state_s = ST_SEARCH;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (timeout_s) begin
          state_s   = ST_SEARCH;
          col_s     = 10'd0;
          row_s     = 10'd0;
          good_s    = 8'd0;
          vs_seen_s = 1'b0;
          tmo_s     = 12'd0;
        end else begin
          col_s = hs_fall_s ? H_SYNC : col_inc_s;
          // VSync reload wins over the end-of-line row increment
          if (vs_fall_s) begin
            row_s = V_SYNC;
          end else if (!hs_fall_s && (col_r == H_LAST)) begin
            row_s = row_inc_s;
          end else begin
            row_s = row_r;
          end
          if (hs_fall_s) begin
            tmo_s = 12'd0;
          end else begin
            tmo_s = tmo_r + 12'd1;
          end
          if (state_r == ST_TRACK) begin
            vs_seen_s = vs_seen_r | vs_fall_s;
            if (match_s) begin
              good_s = (good_r == LOCK_CNT) ? good_r : good_r + 8'd1;
            end else if (hs_fall_s) begin
              good_s = 8'd0;
            end else begin
              good_s = good_r;
            end
            state_s = ((good_s == LOCK_CNT) && vs_seen_s) ? ST_LOCKED : ST_TRACK;
          end else if (hs_fall_s && !match_s) begin
            state_s   = ST_TRACK;
            good_s    = 8'd0;
            vs_seen_s = 1'b0;
          end else begin
            state_s = ST_LOCKED;
          end
        end
      end
      default: begin
        state_s   = ST_SEARCH;
        col_s     = 10'd0;
        row_s     = 10'd0;
        good_s    = 8'd0;
        vs_seen_s = 1'b0;
        tmo_s     = 12'd0;
      end
    endcase
  end

  assign active_s = (state_s == ST_LOCKED) && (col_s < H_ACT) && (row_s < V_ACT);

  // State, counters and registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r       <= ST_SEARCH;
      col_r         <= 10'd0;
      row_r         <= 10'd0;
      good_r        <= 8'd0;
      vs_seen_r     <= 1'b0;
      tmo_r         <= 12'd0;
      active_r      <= 1'b0;
      locked_r      <= 1'b0;
      frame_start_r <= 1'b0;
      rgb_out_r     <= 9'd0;
    end else begin
      state_r       <= state_s;
      col_r         <= col_s;
      row_r         <= row_s;
      good_r        <= good_s;
      vs_seen_r     <= vs_seen_s;
      tmo_r         <= tmo_s;
      active_r      <= active_s;
      locked_r      <= (state_s == ST_LOCKED);
      frame_start_r <= (state_s == ST_LOCKED) && (col_s == 10'd0) && (row_s == 10'd0);
      rgb_out_r     <= active_s ? s1_rgb_r : 9'd0;
    end
  end

  assign o_col_num     = col_r;
  assign o_row_num     = row_r;
  assign o_active      = active_r;
  assign o_locked      = locked_r;
  assign o_frame_start = frame_start_r;
  assign o_reds        = rgb_out_r[8:6];
  assign o_greens      = rgb_out_r[5:3];
  assign o_blues       = rgb_out_r[2:0];

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 32x16 raster (HSync cols 24-27, VSync rows 12-13).
// Honours VGA_RX_SYNC_EN by expecting 4-cycle instead of 2-cycle latency.
module tb_vga_sync_receiver;

  localparam int HT = 32, VT = 16, HA = 20, VA = 10, HS = 24, VS = 12, LL = 4;
  localparam int FR = HT * VT;
`ifdef VGA_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       i_Reset, i_HSync, i_VSync;
  logic [2:0] i_Red, i_Grn, i_Blu;
  logic [9:0] o_col_num, o_row_num;
  logic       o_active, o_locked, o_frame_start;
  logic [2:0] o_reds, o_greens, o_blues;

  int n_chk = 0;
  int n_pass = 0;
  int fs_cnt = 0;
  int tx_col = 0, tx_row = 0;
  bit hold_hs = 1'b0, glitch_en = 1'b0, in_glitch = 1'b0;
  bit lk_model = 1'b0, cv_model = 1'b0;
  int hc[4], hr[4];
  bit hl[4], hcv[4], hsk[4], hno[4];

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_COL(HS), .V_SYNC_ROW(VS), .LOCK_LINES(LL)
  ) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
    .o_col_num(o_col_num), .o_row_num(o_row_num), .o_active(o_active),
    .o_locked(o_locked), .o_frame_start(o_frame_start),
    .o_reds(o_reds), .o_greens(o_greens), .o_blues(o_blues)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare outputs against the pixel driven LAT-1 steps ago
  task automatic check_out();
    int k;
    bit ea, efs;
    logic [2:0] er, eg, eb;
    k = LAT - 1;
    if (!hno[k]) begin
      if (hsk[k]) begin
        check("locked_glitch", {31'd0, o_locked}, {31'd0, hl[k]});
      end else begin
        ea  = hl[k] && (hc[k] < HA) && (hr[k] < VA);
        efs = hl[k] && (hc[k] == 0) && (hr[k] == 0);
        er  = ea ? 3'(hc[k]) : 3'd0;
        eg  = ea ? 3'(hr[k]) : 3'd0;
        eb  = ea ? 3'd5 : 3'd0;
        check("status", {20'd0, o_locked, o_active, o_frame_start, o_reds, o_greens, o_blues},
              {20'd0, hl[k], ea, efs, er, eg, eb});
        if (hcv[k]) check("col", {22'd0, o_col_num}, 32'(hc[k]));
        if (hl[k]) check("row", {22'd0, o_row_num}, 32'(hr[k]));
      end
    end
    if (o_frame_start) fs_cnt++;
  endtask

  task automatic step(input bit do_chk);
    bit act, sk;
    act = (tx_col < HA) && (tx_row < VA);
    i_HSync = hold_hs || !((tx_col >= HS) && (tx_col < HS + 4));
    i_VSync = !((tx_row >= VS) && (tx_row < VS + 2));
    i_Red = act ? 3'(tx_col) : 3'd0;
    i_Grn = act ? 3'(tx_row) : 3'd0;
    i_Blu = act ? 3'd5 : 3'd0;
    sk = in_glitch && (tx_col < HS);
    if (!hold_hs && tx_col == HS) cv_model = 1'b1;
    if (!hold_hs && tx_col == 0 && tx_row == VS) lk_model = 1'b1;
    if (in_glitch && tx_col == HS) begin
      lk_model  = 1'b0;
      in_glitch = 1'b0;
    end
    for (int i = 3; i > 0; i--) begin
      hc[i] = hc[i-1]; hr[i] = hr[i-1]; hl[i] = hl[i-1];
      hcv[i] = hcv[i-1]; hsk[i] = hsk[i-1]; hno[i] = hno[i-1];
    end
    hc[0] = tx_col; hr[0] = tx_row; hl[0] = lk_model;
    hcv[0] = cv_model; hsk[0] = sk; hno[0] = hold_hs;
    @(posedge clk);
    #1;
    if (do_chk) check_out();
    // Shortened line: column HT-1 of row 3 is dropped
    if (glitch_en && tx_row == 3 && tx_col == HT - 2) begin
      tx_col = 0; tx_row = 4; glitch_en = 1'b0; in_glitch = 1'b1;
    end else begin
      tx_col++;
      if (tx_col == HT) begin
        tx_col = 0;
        tx_row = (tx_row + 1) % VT;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_col"}, {22'd0, o_col_num}, 32'd0);
    check({tag, "_row"}, {22'd0, o_row_num}, 32'd0);
    check({tag, "_active"}, {31'd0, o_active}, 32'd0);
    check({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
    check({tag, "_fstart"}, {31'd0, o_frame_start}, 32'd0);
    check({tag, "_rgb"}, {23'd0, o_reds, o_greens, o_blues}, 32'd0);
  endtask

  initial begin
    i_Reset = 1'b1; i_HSync = 1'b1; i_VSync = 1'b1;
    i_Red = 3'd0; i_Grn = 3'd0; i_Blu = 3'd0;
    for (int i = 0; i < 4; i++) begin
      hc[i] = 0; hr[i] = 0; hl[i] = 1'b0; hcv[i] = 1'b0; hsk[i] = 1'b0; hno[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    i_Reset = 1'b0;

    // Ideal stream: lock at (VS,0) of frame 0, one frame-start pulse in frame 1
    run(FR);
    fs_cnt = 0;
    run(FR);
    check("fs_per_frame", 32'(fs_cnt), 32'd1);
    check("locked_frame1", {31'd0, o_locked}, 32'd1);

    // One short line: unlock at the next HSync, relock at the next VSync
    glitch_en = 1'b1;
    run(FR);
    check("relock_glitch", {31'd0, o_locked}, 32'd1);

    // HSync held high long past the timeout
    hold_hs = 1'b1;
    run(100);
    hold_hs = 1'b0;
    check("timeout_locked", {31'd0, o_locked}, 32'd0);
    check("timeout_col", {22'd0, o_col_num}, 32'd0);
    check("timeout_row", {22'd0, o_row_num}, 32'd0);
    check("timeout_active", {31'd0, o_active}, 32'd0);
    tx_col = 0; tx_row = 0; lk_model = 1'b0; cv_model = 1'b0;
    run(FR);
    check("relock_timeout", {31'd0, o_locked}, 32'd1);

    // Single-cycle reset mid-line
    run(40);
    i_Reset = 1'b1;
    step(1'b0);
    i_Reset = 1'b0;
    check_zero("midreset");
    lk_model = 1'b0; cv_model = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hl[i] = 1'b0; hcv[i] = 1'b0;
    end
    run(FR);
    check("relock_reset", {31'd0, o_locked}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
